dac_spi_tx: RTL and testbench
=============================

# dac_spi_tx

Serial output stage for the DAC path: accepts 8-bit samples from the waveform generators (square, and the other wave sources that share the 8-bit sample bus) over a valid/ready handshake. Each sample is formatted into a 16-bit write frame for an external MCP4901-class SPI DAC. The frame is shifted out in SPI mode 0, followed by an LDAC pulse so the analog output updates exactly once per accepted sample. A one-entry holding buffer lets the generator present the next sample while the current frame is on the wire.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 1..255.
- CFG, 4'b0011: 4 config bits sent ahead of the data (write DAC A, unbuffered, gain 1x, output active).
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sample_in  input  8  unsigned DAC code from the upstream generator.
- sample_valid  input  1  sample_in is valid this cycle.
- sample_ready  output  1  block can accept a sample this cycle.
- sclk  output  1  SPI clock; idles low.
- mosi  output  1  SPI data, MSB first.
- cs_n  output  1  DAC chip select, active low.
- ldac_n  output  1  DAC latch strobe, active low.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- Reset values: sclk=0, mosi=0, cs_n=1, ldac_n=1, busy=0, sample_ready=1. The buffer is empty and the state is IDLE.
- Accept: on an edge where sample_valid && sample_ready, sample_in is written to the holding buffer, which becomes full. sample_ready = !buf_full, decoded from a register only, with no combinational path from sample_valid.
- Frame word: {CFG[3:0], sample[7:0], 4'b0000}, 16 bits, sent MSB first.
- States:
  - IDLE: if buf_full, load the frame into the shift register, clear buf_full, drive cs_n=0 and mosi=frame[15], then go to SETUP.
  - SETUP: lasts CLK_DIV cycles with sclk low, then goes to SHIFT.
  - SHIFT: 32 half-periods of CLK_DIV cycles each. sclk toggles at each half-period boundary, first transition rising. On each falling edge except the last, mosi advances to the next bit. After the 32nd half-period, with sclk low, drive cs_n=1 and go to HOLD.
  - HOLD: lasts CLK_DIV cycles with cs_n high, then drives ldac_n=0 and goes to LDAC.
  - LDAC: lasts CLK_DIV cycles, then drives ldac_n=1 and returns to IDLE.
- The buffer may be refilled any time it is empty, including while a frame is in flight. A refill during the frame is sent as the next frame.
- Simultaneous events:
  - Load and accept on the same edge cannot occur, because ready is low while the buffer is full.
  - A buffer emptied on edge N can accept a new sample on edge N+1.
- Samples are never dropped or overwritten. Backpressure is the only flow control.
- Reset mid-frame: all outputs return to their reset values immediately, asynchronously. cs_n rises with fewer than 16 SCLK edges, so the DAC discards the partial frame. The buffered sample is lost.

## Timing
- Accept on edge N (buffer empty, IDLE): cs_n falls after edge N+1.
- First sclk rise: CLK_DIV cycles after cs_n falls.
- cs_n low: 33*CLK_DIV cycles.
- Frame duration, from cs_n fall to ldac_n rise: 35*CLK_DIV cycles. With CLK_DIV=4 this is 140 cycles.
- Maximum sustained rate: one sample per 35*CLK_DIV+1 cycles.
- Setup and hold: mosi is stable for CLK_DIV cycles on each side of every sclk rising edge.
- Timer: one down-counter of width $clog2(CLK_DIV+1), reloaded on every state entry and every half-period boundary. A half-period shift counter of 6 bits counts 0..31.

## Structure
- Package dac_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, HOLD, LDAC);
  - FRAME_W=16 and SAMPLE_W=8;
  - DAC_CFG_DEFAULT=4'b0011.
- Sub-module dac_tick_gen: a CLK_DIV half-period tick generator with a synchronous restart input. dac_spi_tx uses it to time every state. Everything else stays in dac_spi_tx.

## Test plan
- Single frame: CLK_DIV=4, sample 0xFF, one-cycle valid.
  - Bits captured on sclk rise = 0x3FF0.
  - cs_n low for 132 cycles; ldac_n low for 4 cycles, 4 cycles after cs_n rises.
  - busy high for 140 cycles.
- Back-to-back: 0x00 then 0x80, with valid held.
  - Second sample accepted one cycle after the first frame loads; ready is low until the next load.
  - Frames 0x3000 then 0x3800, separated by an IDLE gap of exactly 1 cycle.
- Backpressure: three samples 0x11, 0x22, 0x33, with valid held continuously.
  - Each sample is accepted only while ready=1.
  - Three frames are sent in order; no duplicates or losses.
- Reset mid-frame: assert rst_n low after the 5th sclk rise.
  - Outputs take their reset values in the same cycle.
  - After release, a new sample 0x5A produces a clean frame 0x35A0.
- Edge divisor: CLK_DIV=1, sample 0xA5.
  - Frame 0x3A50 with a 2-cycle SCLK period and a 35-cycle frame.
  - mosi never changes on the same edge where sclk rises.
- Integration: drive the block from the square generator with a one-cycle valid pulse per level change.
  - Frames alternate 0x3000 and 0x3FF0.
  - No frame is missed while the half-period of the square wave exceeds 35*CLK_DIV+1 cycles.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types and constants for the MCP4901-class DAC serial path.
package dac_pkg;

  localparam int FRAME_W      = 16;
  localparam int SAMPLE_W     = 8;
  localparam int HALF_PERIODS = 32;

  localparam logic [3:0] DAC_CFG_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    LDAC
  } dac_state_e;

  // Write frame: config nibble, data byte, four don't-care LSBs sent as zero.
  function automatic logic [FRAME_W-1:0] dac_frame(input logic [3:0]          cfg,
                                                   input logic [SAMPLE_W-1:0] sample);
    return {cfg, sample, 4'b0000};
  endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// Half-period tick every CLK_DIV cycles; restart_i holds the count at its reload value.
// Tick is combinational from the counter register, suppressed while restarting.
module dac_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned    CNT_W  = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - CNT_W'(1);
    if (restart_i || (cnt_q == '0)) begin
      cnt_d = RELOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0) && !restart_i;

endmodule

// File: rtl/dac_spi_tx.sv
// Buffers one 8-bit sample and sends it as a mode-0 SPI write frame plus an LDAC pulse.
// Frame takes 35*CLK_DIV cycles; sample_ready drops only while the one-entry buffer is full.
module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [3:0]  CFG     = DAC_CFG_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                sclk,
  output logic                mosi,
  output logic                cs_n,
  output logic                ldac_n,
  output logic                busy
);

  localparam logic [5:0] LAST_HP   = 6'(HALF_PERIODS - 1);
  localparam logic [5:0] LAST_FALL = 6'(HALF_PERIODS - 2);

  dac_state_e          state_q;
  logic [SAMPLE_W-1:0] buf_q;
  logic                buf_full_q;
  logic [FRAME_W-1:0]  shreg_q;
  logic [5:0]          hp_q;
  logic                sclk_q;
  logic                cs_n_q;
  logic                ldac_n_q;
  logic                busy_q;

  logic accept_d;
  logic tick;

  assign accept_d = sample_valid && !buf_full_q;

  dac_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (state_q == IDLE),
    .tick_o    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shreg_q    <= '0;
      hp_q       <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      ldac_n_q   <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      // Accept and load are exclusive: accept needs an empty buffer, load a full one.
      if (accept_d) begin
        buf_q      <= sample_in;
        buf_full_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (buf_full_q) begin
            shreg_q    <= dac_frame(CFG, buf_q);
            buf_full_q <= 1'b0;
            cs_n_q     <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            sclk_q  <= 1'b1;
            hp_q    <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (hp_q == LAST_HP) begin
              cs_n_q  <= 1'b1;
              state_q <= HOLD;
            end else begin
              sclk_q <= ~sclk_q;
              hp_q   <= hp_q + 6'd1;
              // Advance on falling edges only; the final fall leaves bit 0 in place.
              if (sclk_q && (hp_q != LAST_FALL)) begin
                shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            ldac_n_q <= 1'b0;
            state_q  <= LDAC;
          end
        end
        LDAC: begin
          if (tick) begin
            ldac_n_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_ready = !buf_full_q;
  assign sclk         = sclk_q;
  assign mosi         = shreg_q[FRAME_W-1];
  assign cs_n         = cs_n_q;
  assign ldac_n       = ldac_n_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: a CLK_DIV=4 instance and a CLK_DIV=1 instance side by side.
module tb_dac_spi_tx;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] s_in  [2];
  logic       s_vld [2];
  logic       s_rdy [2];
  logic       sclk  [2];
  logic       mosi  [2];
  logic       cs_n  [2];
  logic       ldac_n[2];
  logic       busy  [2];

  dac_spi_tx #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sample_in(s_in[0]), .sample_valid(s_vld[0]),
    .sample_ready(s_rdy[0]), .sclk(sclk[0]), .mosi(mosi[0]), .cs_n(cs_n[0]),
    .ldac_n(ldac_n[0]), .busy(busy[0])
  );

  dac_spi_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sample_in(s_in[1]), .sample_valid(s_vld[1]),
    .sample_ready(s_rdy[1]), .sclk(sclk[1]), .mosi(mosi[1]), .cs_n(cs_n[1]),
    .ldac_n(ldac_n[1]), .busy(busy[1])
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle counter: number of rising edges so far.
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Line monitor, sampled on falling clk edges.
  logic [15:0] sh[2], last_frame[2];
  int nb[2], cs_cnt[2], ld_cnt[2], bz[2], idle[2], lastrise[2], minp[2], maxp[2];
  int cs_fall[2], cs_rise[2], fr[2], ld_gap[2], last_ld[2], last_busy[2], last_gap[2];
  int last_bits[2], last_cs[2], last_minp[2], last_maxp[2];
  int done[2]     = '{0, 0};
  int mosi_bad[2] = '{0, 0};
  logic pv_sclk[2], pv_cs[2], pv_ldac[2], pv_busy[2], pv_mosi[2];
  logic [15:0] fq0[$];

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        nb[i] = 0; sh[i] = '0; cs_cnt[i] = 0; ld_cnt[i] = 0; bz[i] = 0; idle[i] = 0;
        pv_sclk[i] = 1'b0; pv_cs[i] = 1'b1; pv_ldac[i] = 1'b1; pv_busy[i] = 1'b0;
        pv_mosi[i] = 1'b0; lastrise[i] = -1; cs_rise[i] = 0;
      end else begin
        if (pv_cs[i] && !cs_n[i]) begin
          cs_fall[i] = cyc; nb[i] = 0; sh[i] = '0; cs_cnt[i] = 0;
          lastrise[i] = -1; minp[i] = 1000; maxp[i] = 0;
        end
        if (!cs_n[i]) cs_cnt[i]++;
        if (!pv_sclk[i] && sclk[i]) begin
          sh[i] = {sh[i][14:0], mosi[i]};
          nb[i]++;
          if (nb[i] == 1) fr[i] = cyc;
          if (mosi[i] !== pv_mosi[i]) mosi_bad[i]++;
          if (lastrise[i] >= 0) begin
            if (cyc - lastrise[i] < minp[i]) minp[i] = cyc - lastrise[i];
            if (cyc - lastrise[i] > maxp[i]) maxp[i] = cyc - lastrise[i];
          end
          lastrise[i] = cyc;
        end
        if (!pv_cs[i] && cs_n[i]) begin
          cs_rise[i] = cyc; last_frame[i] = sh[i]; last_bits[i] = nb[i];
          last_cs[i] = cs_cnt[i]; last_minp[i] = minp[i]; last_maxp[i] = maxp[i];
          if (i == 0) fq0.push_back(sh[i]);
        end
        if (pv_ldac[i] && !ldac_n[i]) begin
          ld_gap[i] = cyc - cs_rise[i];
          ld_cnt[i] = 0;
        end
        if (!ldac_n[i]) ld_cnt[i]++;
        if (!pv_ldac[i] && ldac_n[i]) begin
          last_ld[i] = ld_cnt[i];
          done[i]++;
        end
        if (!pv_busy[i] && busy[i]) begin
          last_gap[i] = idle[i];
          bz[i] = 0;
        end
        if (pv_busy[i] && !busy[i]) begin
          last_busy[i] = bz[i];
          idle[i] = 0;
        end
        if (busy[i]) bz[i]++; else idle[i]++;
        pv_sclk[i] = sclk[i]; pv_cs[i] = cs_n[i]; pv_ldac[i] = ldac_n[i];
        pv_busy[i] = busy[i]; pv_mosi[i] = mosi[i];
      end
    end
  end

  // Samples to push and the edge on which each was accepted.
  logic [7:0] tx[$];
  int         acc[$];

  // Call at a falling edge; holds valid until every queued sample is taken.
  task automatic stream(input int i);
    int guard = 0;
    while (tx.size() > 0 && guard < 2000) begin
      s_in[i]  = tx[0];
      s_vld[i] = 1'b1;
      if (s_rdy[i]) begin
        acc.push_back(cyc + 1);
        void'(tx.pop_front());
      end
      @(negedge clk);
      guard++;
    end
    s_vld[i] = 1'b0;
    if (tx.size() > 0) check("stream_timeout", tx.size(), 0);
  endtask

  task automatic wait_done(input int i, input int target, input int budget, input string tag);
    int n = 0;
    while (done[i] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done[i] >= target), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;
  int base1;
  int n;
  logic lvl;

  initial begin
    s_in[0] = '0; s_in[1] = '0; s_vld[0] = 1'b0; s_vld[1] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      check($sformatf("reset_outs%0d", i),
            {sclk[i], mosi[i], cs_n[i], ldac_n[i], busy[i], s_rdy[i]}, 6'b001101);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame, CLK_DIV=4
    tx = '{8'hFF};
    stream(0);
    check("sf_cs_before_load", cs_n[0], 1'b1);
    check("sf_rdy_full", s_rdy[0], 1'b0);
    @(negedge clk);
    check("sf_cs_fall", cs_n[0], 1'b0);
    check("sf_rdy_after_load", s_rdy[0], 1'b1);
    wait_done(0, 1, 400, "sf_done");
    check("sf_frame", last_frame[0], 16'h3FF0);
    check("sf_bits", last_bits[0], 16);
    check("sf_first_rise", fr[0] - cs_fall[0], 4);
    check("sf_cs_low", last_cs[0], 132);
    check("sf_ldac_gap", ld_gap[0], 4);
    check("sf_ldac_low", last_ld[0], 4);
    check("sf_busy", last_busy[0], 140);
    check("sf_q", fq0.pop_front(), 16'h3FF0);

    // Back-to-back with valid held
    repeat (5) @(negedge clk);
    base = done[0];
    acc.delete();
    tx = '{8'h00, 8'h80};
    stream(0);
    check("b2b_acc_gap", acc[1] - acc[0], 2);
    check("b2b_acc_after_load", acc[1] - cs_fall[0], 1);
    wait_done(0, base + 2, 800, "b2b_done");
    check("b2b_f0", fq0.pop_front(), 16'h3000);
    check("b2b_f1", fq0.pop_front(), 16'h3800);
    check("b2b_idle_gap", last_gap[0], 1);

    // Backpressure: three samples, valid held throughout
    repeat (5) @(negedge clk);
    base = done[0];
    acc.delete();
    tx = '{8'h11, 8'h22, 8'h33};
    stream(0);
    check("bp_acc01", acc[1] - acc[0], 2);
    check("bp_acc12", acc[2] - acc[1], 141);
    wait_done(0, base + 3, 1000, "bp_done");
    repeat (200) @(negedge clk);
    check("bp_count", done[0] - base, 3);
    check("bp_f0", fq0.pop_front(), 16'h3110);
    check("bp_f1", fq0.pop_front(), 16'h3220);
    check("bp_f2", fq0.pop_front(), 16'h3330);
    check("bp_no_extra", fq0.size(), 0);

    // Reset mid-frame with a second sample waiting in the buffer
    base = done[0];
    acc.delete();
    tx = '{8'h77, 8'h44};
    stream(0);
    n = 0;
    while (nb[0] < 5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rst_rises", nb[0], 5);
    #1 rst_n = 1'b0;
    #1 check("rst_async_outs",
             {sclk[0], mosi[0], cs_n[0], ldac_n[0], busy[0], s_rdy[0]}, 6'b001101);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_idle_busy", busy[0], 1'b0);
    check("rst_no_frames", done[0] - base, 0);
    check("rst_q_empty", fq0.size(), 0);
    tx = '{8'h5A};
    stream(0);
    wait_done(0, base + 1, 400, "rst_done");
    check("rst_frame", last_frame[0], 16'h35A0);
    check("rst_bits", last_bits[0], 16);
    check("rst_q", fq0.pop_front(), 16'h35A0);

    // CLK_DIV=1 instance
    base1 = done[1];
    tx = '{8'hA5};
    stream(1);
    wait_done(1, base1 + 1, 200, "d1_done");
    check("d1_frame", last_frame[1], 16'h3A50);
    check("d1_bits", last_bits[1], 16);
    check("d1_first_rise", fr[1] - cs_fall[1], 1);
    check("d1_period_min", last_minp[1], 2);
    check("d1_period_max", last_maxp[1], 2);
    check("d1_cs_low", last_cs[1], 33);
    check("d1_busy", last_busy[1], 35);

    // Square generator feeding DUT: one-cycle valid per level change, 200-cycle half-period
    base = done[0];
    lvl  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (199) @(negedge clk);
      lvl = ~lvl;
      check($sformatf("sq_rdy%0d", k), s_rdy[0], 1'b1);
      s_in[0]  = lvl ? 8'hFF : 8'h00;
      s_vld[0] = 1'b1;
      @(negedge clk);
      s_vld[0] = 1'b0;
    end
    wait_done(0, base + 4, 400, "sq_done");
    check("sq_f0", fq0.pop_front(), 16'h3FF0);
    check("sq_f1", fq0.pop_front(), 16'h3000);
    check("sq_f2", fq0.pop_front(), 16'h3FF0);
    check("sq_f3", fq0.pop_front(), 16'h3000);

    check("mosi_stable_d4", mosi_bad[0], 0);
    check("mosi_stable_d1", mosi_bad[1], 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
